bit_demux_collector: RTL and testbench

//  Write-side counterpart of the bit-select mux: steers a 1-bit input stream into

---
 rtl/bit_demux_collector_pkg.sv | 14 +
 rtl/bit_onehot_decoder.sv | 33 +++
 rtl/bit_demux_collector.sv | 137 +++++++++++++
 tb/tb_bit_demux_collector.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_demux_collector_pkg.sv
// Shared types and constants for the serial-to-parallel bit collector.
package bit_demux_collector_pkg;

   // Collector FSM: filling positions, or holding a complete vector for the consumer.
   typedef enum logic {
      StFill = 1'b0,
      StFull = 1'b1
   } state_e;

   // Values of sel_mode.
   localparam logic MODE_AUTO = 1'b0;
   localparam logic MODE_ADDR = 1'b1;

endpackage

// File: rtl/bit_onehot_decoder.sv
// Index to one-hot write-enable decoder with an out-of-range flag for
// non-power-of-2 widths.
module bit_onehot_decoder
   import bit_demux_collector_pkg::*;
#(
   parameter int unsigned  WIDTH = 8,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_onehot,
   output logic             o_out_of_range
);

   // One extra bit so WIDTH itself is representable for the range compare.
   localparam int unsigned     CMP_W   = IDX_W + 1;
   localparam logic [CMP_W-1:0] WIDTH_C = CMP_W'(WIDTH);

   logic [CMP_W-1:0] w_idx_ext;

   assign w_idx_ext = {1'b0, i_idx};

   // Decode the index; indices >= WIDTH match no position, so nothing is written.
   always_comb begin
      o_onehot = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         o_onehot[i] = i_en && (w_idx_ext == CMP_W'(i));
      end
   end

   assign o_out_of_range = i_en && (w_idx_ext >= WIDTH_C);

endmodule

// File: rtl/bit_demux_collector.sv
// Steers a serial bit stream into positions of a WIDTH-bit vector (auto-increment
// or addressed) and presents the completed vector on a valid/ready output.
module bit_demux_collector
   import bit_demux_collector_pkg::*;
#(
   parameter int unsigned  WIDTH = 8,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_bit,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic             i_sel_mode,
   input  logic [IDX_W-1:0] i_sel,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_out_vec,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [IDX_W-1:0] o_bit_idx,
   output logic             o_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e           r_state,     w_state_d;
   logic [WIDTH-1:0] r_shadow,    w_shadow_d;
   logic [WIDTH-1:0] r_mask,      w_mask_d;
   logic [WIDTH-1:0] r_out_vec,   w_out_vec_d;
   logic [IDX_W-1:0] r_ptr,       w_ptr_d;
   logic             r_out_valid, w_out_valid_d;
   logic             r_err,       w_err_d;

   logic             w_accept;
   logic             w_oor;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_ptr_inc;
   logic [WIDTH-1:0] w_onehot;
   logic [WIDTH-1:0] w_merged;
   logic [WIDTH-1:0] w_mask_new;

   assign w_accept   = i_in_valid & (r_state == StFill);
   assign w_idx      = (i_sel_mode == MODE_ADDR) ? i_sel : r_ptr;
   assign w_ptr_inc  = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
   assign w_merged   = (r_shadow & ~w_onehot) | (w_onehot & {WIDTH{i_in_bit}});
   assign w_mask_new = r_mask | w_onehot;

   bit_onehot_decoder #(
      .WIDTH (WIDTH)
   ) u_decoder (
      .i_idx          (w_idx),
      .i_en           (w_accept),
      .o_onehot       (w_onehot),
      .o_out_of_range (w_oor)
   );

   // Next-state logic: flush dominates, then the FILL write or FULL release.
   always_comb begin
      w_state_d     = r_state;
      w_shadow_d    = r_shadow;
      w_mask_d      = r_mask;
      w_ptr_d       = r_ptr;
      w_out_vec_d   = r_out_vec;
      w_out_valid_d = r_out_valid;
      w_err_d       = 1'b0;

      if (i_flush) begin
         w_state_d     = StFill;
         w_shadow_d    = '0;
         w_mask_d      = '0;
         w_ptr_d       = '0;
         w_out_valid_d = 1'b0;
      end else begin
         unique case (r_state)
            StFill: begin
               if (w_accept) begin
                  if (w_oor) begin
                     w_err_d = 1'b1;
                  end else begin
                     w_shadow_d = w_merged;
                     w_mask_d   = w_mask_new;
                     if (i_sel_mode == MODE_AUTO) begin
                        w_ptr_d = w_ptr_inc;
                     end
                     if (&w_mask_new) begin
                        w_out_vec_d   = w_merged;
                        w_out_valid_d = 1'b1;
                        w_state_d     = StFull;
                     end
                  end
               end
            end
            StFull: begin
               // Release cycle accepts no beat, leaving one bubble before refill.
               if (i_out_ready) begin
                  w_state_d     = StFill;
                  w_out_valid_d = 1'b0;
                  w_shadow_d    = '0;
                  w_mask_d      = '0;
                  w_ptr_d       = '0;
               end
            end
            default: begin
               w_state_d = StFill;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StFill;
         r_shadow    <= '0;
         r_mask      <= '0;
         r_ptr       <= '0;
         r_out_vec   <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_shadow    <= w_shadow_d;
         r_mask      <= w_mask_d;
         r_ptr       <= w_ptr_d;
         r_out_vec   <= w_out_vec_d;
         r_out_valid <= w_out_valid_d;
         r_err       <= w_err_d;
      end
   end

   assign o_in_ready  = (r_state == StFill);
   assign o_out_vec   = r_out_vec;
   assign o_out_valid = r_out_valid;
   assign o_bit_idx   = r_ptr;
   assign o_err       = r_err;

endmodule

// File: tb/tb_bit_demux_collector.sv
// Bench for bit_demux_collector: three instances (WIDTH 2, 8, 6) run in lockstep
// against a behavioural model, with directed scenarios followed by random traffic.
module tb_bit_demux_collector;

   logic       clk;
   logic       rst_n;
   logic [2:0] in_bit;
   logic [2:0] in_valid;
   logic [2:0] sel_mode;
   logic [2:0] flush;
   logic [2:0] out_ready;
   logic [2:0] sel_a [3];

   logic [2:0] in_ready;
   logic [2:0] out_valid;
   logic [2:0] err;
   logic [1:0] ov0;
   logic [7:0] ov1;
   logic [5:0] ov2;
   logic [0:0] bi0;
   logic [2:0] bi1;
   logic [2:0] bi2;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Behavioural model state per instance.
   int unsigned wid     [3];
   int unsigned sel_max [3];
   bit          m_full  [3];
   bit [7:0]    m_wr    [3];
   bit [7:0]    m_val   [3];
   int unsigned m_ptr   [3];
   int unsigned m_vec   [3];
   bit          m_err   [3];

   bit_demux_collector #(.WIDTH(2)) u_dut_w2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_bit(in_bit[0]), .i_in_valid(in_valid[0]),
      .o_in_ready(in_ready[0]), .i_sel_mode(sel_mode[0]), .i_sel(sel_a[0][0:0]),
      .i_flush(flush[0]), .o_out_vec(ov0), .o_out_valid(out_valid[0]),
      .i_out_ready(out_ready[0]), .o_bit_idx(bi0), .o_err(err[0])
   );

   bit_demux_collector #(.WIDTH(8)) u_dut_w8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_bit(in_bit[1]), .i_in_valid(in_valid[1]),
      .o_in_ready(in_ready[1]), .i_sel_mode(sel_mode[1]), .i_sel(sel_a[1]),
      .i_flush(flush[1]), .o_out_vec(ov1), .o_out_valid(out_valid[1]),
      .i_out_ready(out_ready[1]), .o_bit_idx(bi1), .o_err(err[1])
   );

   bit_demux_collector #(.WIDTH(6)) u_dut_w6 (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_bit(in_bit[2]), .i_in_valid(in_valid[2]),
      .o_in_ready(in_ready[2]), .i_sel_mode(sel_mode[2]), .i_sel(sel_a[2]),
      .i_flush(flush[2]), .o_out_vec(ov2), .o_out_valid(out_valid[2]),
      .i_out_ready(out_ready[2]), .o_bit_idx(bi2), .o_err(err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic get_out(input int k, output logic [31:0] vec, output logic [31:0] idx);
      case (k)
         0:       begin vec = 32'(ov0); idx = 32'(bi0); end
         1:       begin vec = 32'(ov1); idx = 32'(bi1); end
         default: begin vec = 32'(ov2); idx = 32'(bi2); end
      endcase
   endtask

   task automatic model_clear(input int k, input bit hard);
      m_full[k] = 1'b0;
      m_wr[k]   = '0;
      m_val[k]  = '0;
      m_ptr[k]  = 0;
      m_err[k]  = 1'b0;
      if (hard) m_vec[k] = 0;
   endtask

   // One clock of the reference behaviour, from the inputs currently driven.
   task automatic model_step(input int k);
      int unsigned idx;
      bit          all_wr;
      if (!rst_n) begin
         model_clear(k, 1'b1);
      end else if (flush[k]) begin
         model_clear(k, 1'b0);
      end else if (m_full[k]) begin
         m_err[k] = 1'b0;
         if (out_ready[k]) model_clear(k, 1'b0);
      end else begin
         m_err[k] = 1'b0;
         if (in_valid[k]) begin
            idx = sel_mode[k] ? int'(sel_a[k]) : m_ptr[k];
            if (idx >= wid[k]) begin
               m_err[k] = 1'b1;
            end else begin
               m_val[k][idx] = in_bit[k];
               m_wr[k][idx]  = 1'b1;
               if (!sel_mode[k]) m_ptr[k] = (m_ptr[k] + 1) % wid[k];
               all_wr = 1'b1;
               for (int i = 0; i < int'(wid[k]); i++) if (!m_wr[k][i]) all_wr = 1'b0;
               if (all_wr) begin
                  m_vec[k] = 0;
                  for (int i = 0; i < int'(wid[k]); i++) m_vec[k] += int'(m_val[k][i]) << i;
                  m_full[k] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare(input int k);
      logic [31:0] v;
      logic [31:0] bi;
      get_out(k, v, bi);
      chk($sformatf("in_ready_w%0d", wid[k]), 32'(in_ready[k]), 32'(!m_full[k]));
      chk($sformatf("out_valid_w%0d", wid[k]), 32'(out_valid[k]), 32'(m_full[k]));
      chk($sformatf("out_vec_w%0d", wid[k]), v, m_vec[k]);
      chk($sformatf("bit_idx_w%0d", wid[k]), bi, m_ptr[k]);
      chk($sformatf("err_w%0d", wid[k]), 32'(err[k]), 32'(m_err[k]));
   endtask

   // Check outputs against the model, advance the model and the DUT by one clock.
   task automatic tick();
      for (int k = 0; k < 3; k++) compare(k);
      for (int k = 0; k < 3; k++) model_step(k);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      rst_n     = 1'b1;
      in_bit    = '0;
      in_valid  = '0;
      sel_mode  = '0;
      flush     = '0;
      out_ready = '0;
      for (int k = 0; k < 3; k++) sel_a[k] = '0;
   endtask

   task automatic beat(input int k, input logic mode, input logic [2:0] s, input logic b);
      idle();
      in_valid[k] = 1'b1;
      sel_mode[k] = mode;
      sel_a[k]    = s;
      in_bit[k]   = b;
   endtask

   task automatic release_out(input int k);
      idle();
      out_ready[k] = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      logic [7:0] pat8;
      logic [5:0] pat6;
      logic [2:0] addr_list [7];
      logic [31:0] v;
      logic [31:0] bi;

      wid     = '{2, 8, 6};
      sel_max = '{1, 7, 7};
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) model_clear(k, 1'b1);
      rst_n = 1'b1;

      // Reset state, against fixed values.
      chk("rst_in_ready", 32'(in_ready), 32'h7);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_vec_w8", 32'(ov1), 32'h0);
      chk("rst_idx_w8", 32'(bi1), 32'h0);

      // WIDTH=2 auto: bits 1,0 -> 2'b01, valid the cycle after the 2nd beat.
      beat(0, 1'b0, 3'd0, 1'b1); tick();
      beat(0, 1'b0, 3'd0, 1'b0);
      chk("t1_not_early", 32'(out_valid[0]), 32'h0);
      tick(); idle();
      chk("t1_valid", 32'(out_valid[0]), 32'h1);
      chk("t1_vec", 32'(ov0), 32'h1);
      chk("t1_in_ready", 32'(in_ready[0]), 32'h0);
      release_out(0);
      chk("t1_released", 32'(out_valid[0]), 32'h0);

      // WIDTH=2 addressed: sel1=1, sel0=0 -> 2'b10.
      beat(0, 1'b1, 3'd1, 1'b1); tick();
      beat(0, 1'b1, 3'd0, 1'b0); tick(); idle();
      chk("t2_vec", 32'(ov0), 32'h2);
      chk("t2_valid", 32'(out_valid[0]), 32'h1);
      release_out(0);

      // WIDTH=8 auto: 0xA5 LSB first, held through 5 stalled cycles with beats offered.
      pat8 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         beat(1, 1'b0, 3'd0, pat8[i]); tick();
      end
      for (int i = 0; i < 5; i++) begin
         beat(1, 1'b0, 3'd0, 1'b0);
         chk("t3_hold_vec", 32'(ov1), 32'hA5);
         chk("t3_hold_ready", 32'(in_ready[1]), 32'h0);
         tick();
      end
      beat(1, 1'b0, 3'd0, 1'b1);
      out_ready[1] = 1'b1;
      tick(); idle();
      chk("t3_release_valid", 32'(out_valid[1]), 32'h0);
      chk("t3_release_ptr", 32'(bi1), 32'h0);
      chk("t3_release_ready", 32'(in_ready[1]), 32'h1);

      // WIDTH=8 addressed overwrite of position 3, then fill the rest.
      beat(1, 1'b1, 3'd3, 1'b1); tick();
      beat(1, 1'b1, 3'd3, 1'b1); tick();
      beat(1, 1'b1, 3'd3, 1'b0); tick();
      addr_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
      for (int i = 0; i < 7; i++) begin
         idle();
         chk("t4_not_complete", 32'(out_valid[1]), 32'h0);
         beat(1, 1'b1, addr_list[i], 1'b1); tick();
      end
      idle();
      chk("t4_valid", 32'(out_valid[1]), 32'h1);
      chk("t4_vec", 32'(ov1), 32'hF7);
      release_out(1);

      // WIDTH=8 flush mid-frame with a beat offered: beat dropped, mask and ptr cleared.
      for (int i = 0; i < 4; i++) begin
         beat(1, 1'b0, 3'd0, 1'b1); tick();
      end
      beat(1, 1'b0, 3'd0, 1'b1);
      flush[1] = 1'b1;
      tick(); idle();
      chk("t5_ptr", 32'(bi1), 32'h0);
      for (int i = 4; i < 8; i++) begin
         beat(1, 1'b1, 3'(i), 1'b0); tick();
      end
      idle();
      chk("t5_mask_cleared", 32'(out_valid[1]), 32'h0);
      for (int i = 0; i < 4; i++) begin
         beat(1, 1'b0, 3'd0, 1'b1); tick();
      end
      idle();
      chk("t5_vec", 32'(ov1), 32'h0F);
      release_out(1);

      // WIDTH=6: out-of-range select pulses err and writes nothing.
      beat(2, 1'b1, 3'd7, 1'b1); tick(); idle();
      chk("t6_err_pulse", 32'(err[2]), 32'h1);
      tick();
      chk("t6_err_gone", 32'(err[2]), 32'h0);
      pat6 = 6'b101101;
      for (int i = 0; i < 6; i++) begin
         idle();
         chk("t6_not_complete", 32'(out_valid[2]), 32'h0);
         beat(2, 1'b0, 3'd0, pat6[i]); tick();
      end
      idle();
      chk("t6_vec", 32'(ov2), 32'h2D);
      tick();
      rst_n = 1'b0;
      tick(); idle();
      chk("t6_reset_valid", 32'(out_valid[2]), 32'h0);
      chk("t6_reset_vec", 32'(ov2), 32'h0);

      // Random traffic on all three instances.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         for (int k = 0; k < 3; k++) begin
            in_valid[k]  = ($urandom_range(0, 9) < 7);
            in_bit[k]    = 1'($urandom);
            sel_mode[k]  = 1'($urandom);
            sel_a[k]     = 3'($urandom_range(0, sel_max[k]));
            flush[k]     = ($urandom_range(0, 49) == 0);
            out_ready[k] = 1'($urandom);
         end
         tick();
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         get_out(k, v, bi);
         chk($sformatf("final_vec_w%0d", wid[k]), v, m_vec[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
